// File: rtl/rtc_bus_ctrl.sv
// rtl/rtc_bus_ctrl.sv - host-register front end and phase-timed RTC bus sequencer
//
// Purpose: decodes microcontroller port writes/reads into host registers and
// runs an address/data transaction on a multiplexed RTC bus, each bus phase
// lasting T_PHASE clocks.
// Ports:
//   clk, reset              system clock, synchronous active-high reset
//   actRTC, dir, out_port   port select, sub-address and write data from host
//   writestrobe/read_strobe one-cycle host access pulses
//   in_portRTC              registered read data back to host
//   ad_out/ad_oe/ad_in      split multiplexed address/data bus
//   cs_n/rd_n/wr_n/ad_sel   RTC strobes (active-low) and A/D phase select
//   busy                    transaction in progress
module rtc_bus_ctrl #(
  parameter int unsigned T_PHASE = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       actRTC,
  input  logic [7:0] dir,
  input  logic [7:0] out_port,
  input  logic       writestrobe,
  input  logic       read_strobe,
  output logic [7:0] in_portRTC,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  input  logic [7:0] ad_in,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       ad_sel,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_GAP, S_DATA_WR, S_DATA_RD, S_RECOVER
  } state_t;

  localparam logic [7:0] LAST_CNT = 8'(T_PHASE - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] addr_q, wdata_q, rdata_q;
  logic [7:0] work_addr_q, work_wdata_q;
  logic       is_read_q;
  logic       ovr_q;
  logic [7:0] in_port_q;
  logic       cs_n_q, rd_n_q, wr_n_q, ad_sel_q, ad_oe_q;
  logic [7:0] ad_out_q;
  logic       cs_n_d, rd_n_d, wr_n_d, ad_sel_d, ad_oe_d;
  logic [7:0] ad_out_d;

  logic       wr_acc, start_req, start_ok, busy_w, phase_end, ovr_clr;
  logic [7:0] rd_mux;

  assign busy_w    = (state_q != S_IDLE);
  assign wr_acc    = writestrobe && actRTC;
  assign start_req = wr_acc && (dir[1:0] == 2'd1 || dir[1:0] == 2'd2);
  assign start_ok  = start_req && !busy_w;
  assign phase_end = (cnt_q == LAST_CNT);
  // A simultaneous write wins; the status-read side effect is skipped.
  assign ovr_clr   = read_strobe && actRTC && (dir[1:0] == 2'd0) && !writestrobe;

  always_comb begin
    case (dir[1:0])
      2'd0:    rd_mux = {6'b0, ovr_q, busy_w};
      2'd1:    rd_mux = rdata_q;
      default: rd_mux = 8'h00;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == S_IDLE) begin
      cnt_d = 8'd0;
      if (start_ok) state_d = S_ADDR;
    end else if (phase_end) begin
      cnt_d = 8'd0;
      case (state_q)
        S_ADDR:    state_d = S_GAP;
        S_GAP:     state_d = is_read_q ? S_DATA_RD : S_DATA_WR;
        S_DATA_WR: state_d = S_RECOVER;
        S_DATA_RD: state_d = S_RECOVER;
        default:   state_d = S_IDLE;
      endcase
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Bus outputs are decoded from the next state so the registered pins line
  // up with state_q. On the ADDR entry edge the working address is not yet
  // loaded, so the live ADDR_REG is used directly.
  always_comb begin
    cs_n_d   = 1'b1;
    rd_n_d   = 1'b1;
    wr_n_d   = 1'b1;
    ad_sel_d = 1'b0;
    ad_oe_d  = 1'b0;
    ad_out_d = 8'h00;
    case (state_d)
      S_ADDR: begin
        cs_n_d   = 1'b0;
        wr_n_d   = 1'b0;
        ad_oe_d  = 1'b1;
        ad_out_d = (state_q == S_IDLE) ? addr_q : work_addr_q;
      end
      S_DATA_WR: begin
        cs_n_d   = 1'b0;
        wr_n_d   = 1'b0;
        ad_sel_d = 1'b1;
        ad_oe_d  = 1'b1;
        ad_out_d = work_wdata_q;
      end
      S_DATA_RD: begin
        cs_n_d   = 1'b0;
        rd_n_d   = 1'b0;
        ad_sel_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= 8'd0;
      addr_q       <= 8'h00;
      wdata_q      <= 8'h00;
      rdata_q      <= 8'h00;
      work_addr_q  <= 8'h00;
      work_wdata_q <= 8'h00;
      is_read_q    <= 1'b0;
      ovr_q        <= 1'b0;
      in_port_q    <= 8'h00;
      cs_n_q       <= 1'b1;
      rd_n_q       <= 1'b1;
      wr_n_q       <= 1'b1;
      ad_sel_q     <= 1'b0;
      ad_oe_q      <= 1'b0;
      ad_out_q     <= 8'h00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      in_port_q <= rd_mux;
      cs_n_q    <= cs_n_d;
      rd_n_q    <= rd_n_d;
      wr_n_q    <= wr_n_d;
      ad_sel_q  <= ad_sel_d;
      ad_oe_q   <= ad_oe_d;
      ad_out_q  <= ad_out_d;
      if (wr_acc && dir[1:0] == 2'd0) addr_q  <= out_port;
      if (wr_acc && dir[1:0] == 2'd1) wdata_q <= out_port;
      if (start_ok) begin
        work_addr_q  <= addr_q;
        work_wdata_q <= (dir[1:0] == 2'd1) ? out_port : wdata_q;
        is_read_q    <= (dir[1:0] == 2'd2);
      end
      if (state_q == S_DATA_RD && phase_end) rdata_q <= ad_in;
      if (start_req && busy_w) ovr_q <= 1'b1;
      else if (ovr_clr)        ovr_q <= 1'b0;
    end
  end

  assign in_portRTC = in_port_q;
  assign ad_out     = ad_out_q;
  assign ad_oe      = ad_oe_q;
  assign cs_n       = cs_n_q;
  assign rd_n       = rd_n_q;
  assign wr_n       = wr_n_q;
  assign ad_sel     = ad_sel_q;
  assign busy       = busy_w;

endmodule

// File: doc/rtc_bus_ctrl.md
RTC_BUS_CTRL -- requirements
Module: rtc_bus_ctrl

Interface
REQ-001 Parameter T_PHASE, default 8, clock cycles per bus phase; legal range 2..255.
REQ-002 clk  in  1  system clock; all logic is clocked on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 actRTC  in  1  port-decode select from the microcontroller stage; qualifies every strobe.
REQ-005 dir  in  8  port sub-address from the microcontroller; bits [1:0] are decoded, bits [7:2] are ignored.
REQ-006 out_port  in  8  write data from the microcontroller.
REQ-007 writestrobe  in  1  one-cycle write pulse (normal OR constant write).
REQ-008 read_strobe  in  1  one-cycle read pulse.
REQ-009 in_portRTC  out  8  registered read data returned to the microcontroller input mux.
REQ-010 ad_out / ad_oe / ad_in  out 8 / out 1 / in 8  split multiplexed RTC address/data bus; the top level builds the tristate.
REQ-011 cs_n, rd_n, wr_n  out  1 each  RTC chip select, read and write strobes, all active-low.
REQ-012 ad_sel  out  1  RTC A/D select: 0 = address phase, 1 = data phase.
REQ-013 busy  out  1  high while a bus transaction is in progress.

Function
REQ-014 Host registers, writes accepted only when writestrobe=1 and actRTC=1:
- dir=0: ADDR_REG <= out_port.
- dir=1: WDATA_REG <= out_port, then start a WRITE transaction.
- dir=2: start a READ transaction; data is ignored.
- dir=3: no effect.
REQ-015 Read map; in_portRTC is updated every cycle with a 1-cycle latency from dir:
- dir=0: status {6'b0, ovr, busy}.
- dir=1: RDATA_REG.
- dir=2 or 3: 0x00.
REQ-016 FSM states: IDLE, ADDR, GAP, DATA_WR, DATA_RD, RECOVER. Each non-IDLE state lasts exactly T_PHASE cycles, counted by a phase counter that clears on every state entry.
REQ-017 Transitions:
- IDLE -> ADDR on an accepted start.
- ADDR -> GAP.
- GAP -> DATA_WR for a write, or DATA_RD for a read.
- DATA_* -> RECOVER.
- RECOVER -> IDLE.
REQ-018 Bus outputs are registered and reflect the current state (idle values apply in IDLE, GAP and RECOVER):
- ADDR: cs_n=0, wr_n=0, ad_sel=0, ad_oe=1, ad_out=ADDR_REG.
- DATA_WR: cs_n=0, wr_n=0, ad_sel=1, ad_oe=1, ad_out=WDATA_REG.
- DATA_RD: cs_n=0, rd_n=0, ad_sel=1, ad_oe=0.
- Idle values: cs_n=1, rd_n=1, wr_n=1, ad_sel=0, ad_oe=0, ad_out=0x00.
REQ-019 Bus drive never overlaps: ad_oe=1 and rd_n=0 are never asserted in the same cycle.
REQ-020 Transaction latency: a start accepted at edge n puts the FSM in ADDR from edge n+1. A transaction lasts 4*T_PHASE cycles. busy=1 exactly in non-IDLE states.
REQ-021 RDATA_REG <= ad_in on the last cycle of DATA_RD only; it is otherwise held.
REQ-022 ADDR_REG and WDATA_REG are snapshotted into working registers at start. Writes to dir 0/1 during busy update ADDR_REG/WDATA_REG but do not alter the bus.
REQ-023 A start request (dir 1 or 2) while busy=1 is dropped and sets ovr=1. ovr clears one cycle after read_strobe=1 with actRTC=1 and dir=0.
REQ-024 A strobe with actRTC=0 has no effect on any register or the FSM.
REQ-025 If writestrobe and read_strobe are both high in the same cycle, the write is processed; the read-side ovr clear is suppressed that cycle.
REQ-026 The phase counter is 8 bits and does not wrap within a state. The transition occurs when count = T_PHASE-1.

Reset
REQ-027 Reset has priority over every other input.
REQ-028 On reset:
- FSM -> IDLE, counter=0, busy=0, ovr=0.
- ADDR_REG, WDATA_REG, RDATA_REG and in_portRTC = 0x00.
- Bus outputs take their idle values on the next edge.
REQ-029 Reset asserted mid-transaction aborts the transaction. No partial data is latched, and cs_n returns high at the edge where reset is sampled.

Verification
REQ-030 Reset check: reset for 3 cycles -> cs_n=rd_n=wr_n=1, ad_oe=0, busy=0, in_portRTC=0x00.
REQ-031 Write transaction: write dir0=0x21, then dir1=0x45 (T_PHASE=8) ->
- 8 cycles of ad_out=0x21, ad_sel=0, cs_n=wr_n=0;
- 8 idle cycles;
- 8 cycles of ad_out=0x45, ad_sel=1;
- 8 idle cycles; busy high for 32 cycles.
REQ-032 Read transaction: write dir0=0x22, then dir2=any, with ad_in=0x59 during DATA_RD -> rd_n=0 and ad_oe=0 for 8 cycles; a later read of dir1 returns 0x59.
REQ-033 Overrun: start a write, then write dir2 while busy -> no second transaction. Status reads 0x03, then 0x00 after busy ends and a further status read.
REQ-034 Mid-transaction reset: reset in cycle 3 of DATA_WR -> next edge cs_n=1, wr_n=1, busy=0. A following read of dir1 returns 0x00.
REQ-035 Deselected access: writestrobe with actRTC=0, dir=1 -> busy stays 0 and all bus outputs stay idle.
